// File: rtl/game_sequencer.sv
// game_sequencer
//
// Top-level controller for the torpedo-versus-target game. It runs the game
// through its start, aim, shoot and end-of-game phases. It drives the load and
// update controls of the two sprite engines and captures the launch direction
// from the steering keys. It decides win or loss from collision and off-screen
// events and times the end-of-game phase with a down-counter.
//
// Ports:
//   clk, reset                      clock; asynchronous active-high reset
//   launch_key                      fire key (synchronized, debounced)
//   key_left, key_right             steering keys, sampled on launch
//   collision                       target/torpedo overlap this cycle
//   target_out, torpedo_out         sprite has left the screen
//   sprite_target_write_xy/dxy      1-cycle load pulses, target sprite
//   sprite_torpedo_write_xy/dxy     1-cycle load pulses, torpedo sprite
//   sprite_target_enable_update     target moves while high
//   sprite_torpedo_enable_update    torpedo moves while high
//   torpedo_dx                      signed torpedo x velocity (-1, 0, +1)
//   game_won                        result of the last game
//   end_of_game_timer_running       high while the end-of-game phase counts
//
// Build option:
//   GAME_SEQUENCER_AUTO_RESTART_EN  when defined, expiry of the end-of-game
//                                   timer starts a new game. When undefined,
//                                   the block parks in DONE until reset.
//
// State table:
//   START | one cycle: load both sprites, clear result and torpedo velocity
//   AIM   | target moves, torpedo waits for a launch
//   SHOOT | both sprites move until a hit or an off-screen event
//   END   | end-of-game timer counts down, sprites frozen
//   DONE  | game over, only game_won stays visible

module game_sequencer #(
    parameter int END_TIMER_WIDTH  = 24,
    parameter int END_TIMER_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       launch_key,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       collision,
    input  logic       target_out,
    input  logic       torpedo_out,
    output logic       sprite_target_write_xy,
    output logic       sprite_target_write_dxy,
    output logic       sprite_torpedo_write_xy,
    output logic       sprite_torpedo_write_dxy,
    output logic       sprite_target_enable_update,
    output logic       sprite_torpedo_enable_update,
    output logic [1:0] torpedo_dx,
    output logic       game_won,
    output logic       end_of_game_timer_running
);

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_AIM   = 3'd1,
        ST_SHOOT = 3'd2,
        ST_END   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [END_TIMER_WIDTH-1:0] END_LOAD =
        END_TIMER_WIDTH'(END_TIMER_CYCLES - 1);

    state_t                     state_q, state_d;
    logic                       boot_q, boot_d;
    logic                       launch_key_q, launch_key_d;
    logic [END_TIMER_WIDTH-1:0] end_cnt_q, end_cnt_d;
    logic                       tgt_wxy_q, tgt_wxy_d;
    logic                       tgt_wdxy_q, tgt_wdxy_d;
    logic                       tor_wxy_q, tor_wxy_d;
    logic                       tor_wdxy_q, tor_wdxy_d;
    logic                       tgt_en_q, tgt_en_d;
    logic                       tor_en_q, tor_en_d;
    logic [1:0]                 torpedo_dx_q, torpedo_dx_d;
    logic                       game_won_q, game_won_d;
    logic                       timer_run_q, timer_run_d;

    logic                       launch;
    logic                       enter_shoot;
    logic [1:0]                 launch_dx;

    assign launch = launch_key & ~launch_key_q;

    // left only -> -1, right only -> +1, none or both -> 0
    always_comb begin
        launch_dx = 2'b00;
        if (key_left && !key_right) begin
            launch_dx = 2'b11;
        end else if (key_right && !key_left) begin
            launch_dx = 2'b01;
        end
    end

    always_comb begin
        state_d      = state_q;
        boot_d       = 1'b1;
        launch_key_d = launch_key;
        end_cnt_d    = end_cnt_q;
        torpedo_dx_d = torpedo_dx_q;
        game_won_d   = game_won_q;
        enter_shoot  = 1'b0;

        // The first edge after reset release re-enters START so that its
        // load pulses become visible for one full cycle.
        if (!boot_q) begin
            state_d = ST_START;
        end else begin
            case (state_q)
                ST_START: begin
                    state_d = ST_AIM;
                end
                ST_AIM: begin
                    if (collision) begin
                        state_d    = ST_END;
                        game_won_d = 1'b1;
                    end else if (target_out) begin
                        state_d    = ST_END;
                        game_won_d = 1'b0;
                    end else if (launch) begin
                        state_d      = ST_SHOOT;
                        enter_shoot  = 1'b1;
                        torpedo_dx_d = launch_dx;
                    end
                end
                ST_SHOOT: begin
                    // A hit wins even if a sprite leaves the screen in the
                    // same cycle.
                    if (collision) begin
                        state_d    = ST_END;
                        game_won_d = 1'b1;
                    end else if (target_out || torpedo_out) begin
                        state_d    = ST_END;
                        game_won_d = 1'b0;
                    end
                end
                ST_END: begin
                    if (end_cnt_q == '0) begin
`ifdef GAME_SEQUENCER_AUTO_RESTART_EN
                        state_d = ST_START;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        end_cnt_d = end_cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_START;
                end
            endcase
        end

        // The counter is loaded only when END is entered, so it cannot wrap.
        if (state_d == ST_END && state_q != ST_END) begin
            end_cnt_d = END_LOAD;
        end

        if (state_d == ST_START) begin
            torpedo_dx_d = 2'b00;
            game_won_d   = 1'b0;
        end
        if (state_d == ST_DONE) begin
            torpedo_dx_d = 2'b00;
        end

        // Outputs are registered from the next state, so they change on the
        // same edge as the state.
        tgt_wxy_d   = (state_d == ST_START);
        tgt_wdxy_d  = (state_d == ST_START);
        tor_wxy_d   = (state_d == ST_START);
        tor_wdxy_d  = (state_d == ST_START) || enter_shoot;
        tgt_en_d    = (state_d == ST_AIM) || (state_d == ST_SHOOT);
        tor_en_d    = (state_d == ST_SHOOT);
        timer_run_d = (state_d == ST_END);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_START;
            boot_q       <= 1'b0;
            launch_key_q <= 1'b0;
            end_cnt_q    <= '0;
            tgt_wxy_q    <= 1'b0;
            tgt_wdxy_q   <= 1'b0;
            tor_wxy_q    <= 1'b0;
            tor_wdxy_q   <= 1'b0;
            tgt_en_q     <= 1'b0;
            tor_en_q     <= 1'b0;
            torpedo_dx_q <= 2'b00;
            game_won_q   <= 1'b0;
            timer_run_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            boot_q       <= boot_d;
            launch_key_q <= launch_key_d;
            end_cnt_q    <= end_cnt_d;
            tgt_wxy_q    <= tgt_wxy_d;
            tgt_wdxy_q   <= tgt_wdxy_d;
            tor_wxy_q    <= tor_wxy_d;
            tor_wdxy_q   <= tor_wdxy_d;
            tgt_en_q     <= tgt_en_d;
            tor_en_q     <= tor_en_d;
            torpedo_dx_q <= torpedo_dx_d;
            game_won_q   <= game_won_d;
            timer_run_q  <= timer_run_d;
        end
    end

    assign sprite_target_write_xy       = tgt_wxy_q;
    assign sprite_target_write_dxy      = tgt_wdxy_q;
    assign sprite_torpedo_write_xy      = tor_wxy_q;
    assign sprite_torpedo_write_dxy     = tor_wdxy_q;
    assign sprite_target_enable_update  = tgt_en_q;
    assign sprite_torpedo_enable_update = tor_en_q;
    assign torpedo_dx                   = torpedo_dx_q;
    assign game_won                     = game_won_q;
    assign end_of_game_timer_running    = timer_run_q;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

    localparam int END_CYC = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       launch_key, key_left, key_right;
    logic       collision, target_out, torpedo_out;
    logic       t_wxy, t_wdxy, p_wxy, p_wdxy, t_en, p_en;
    logic [1:0] torpedo_dx;
    logic       game_won, running;

    int checks = 0;
    int errors = 0;

    game_sequencer #(
        .END_TIMER_WIDTH (8),
        .END_TIMER_CYCLES(END_CYC)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .launch_key                  (launch_key),
        .key_left                    (key_left),
        .key_right                   (key_right),
        .collision                   (collision),
        .target_out                  (target_out),
        .torpedo_out                 (torpedo_out),
        .sprite_target_write_xy      (t_wxy),
        .sprite_target_write_dxy     (t_wdxy),
        .sprite_torpedo_write_xy     (p_wxy),
        .sprite_torpedo_write_dxy    (p_wdxy),
        .sprite_target_enable_update (t_en),
        .sprite_torpedo_enable_update(p_en),
        .torpedo_dx                  (torpedo_dx),
        .game_won                    (game_won),
        .end_of_game_timer_running   (running)
    );

    always #5 clk = ~clk;

    logic [9:0] dut_vec;
    assign dut_vec = {t_wxy, t_wdxy, p_wxy, p_wdxy, t_en, p_en, torpedo_dx, game_won, running};

    // Behavioural model: game phase, remaining end-of-game cycles, result.
    localparam int PH_IDLE = 0, PH_START = 1, PH_AIM = 2, PH_SHOOT = 3, PH_END = 4, PH_DONE = 5;
    int         m_ph;
    int         m_left;
    int         m_vel;
    bit         m_won, m_first, m_prev, m_launch;
    logic [1:0] m_dx;

    initial begin
        m_ph = PH_IDLE; m_left = 0; m_won = 0; m_first = 0; m_prev = 0; m_dx = 2'b00;
        m_vel = 0; m_launch = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_ph = PH_IDLE; m_left = 0; m_won = 0; m_first = 0; m_prev = 0; m_dx = 2'b00;
            end else begin
                m_launch = launch_key && !m_prev;
                m_prev   = launch_key;
                m_first  = 0;
                case (m_ph)
                    PH_IDLE:  m_ph = PH_START;
                    PH_START: m_ph = PH_AIM;
                    PH_AIM, PH_SHOOT: begin
                        if (collision) begin
                            m_won = 1; m_ph = PH_END; m_left = END_CYC;
                        end else if (target_out || (m_ph == PH_SHOOT && torpedo_out)) begin
                            m_won = 0; m_ph = PH_END; m_left = END_CYC;
                        end else if (m_ph == PH_AIM && m_launch) begin
                            m_vel   = int'(key_right) - int'(key_left);
                            m_dx    = 2'(m_vel);
                            m_first = 1;
                            m_ph    = PH_SHOOT;
                        end
                    end
                    PH_END: begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
`ifdef GAME_SEQUENCER_AUTO_RESTART_EN
                            m_ph = PH_START;
`else
                            m_ph = PH_DONE;
`endif
                        end
                    end
                    default: ;
                endcase
                if (m_ph == PH_START) begin
                    m_won = 0; m_dx = 2'b00;
                end
            end
        end
    end

    function automatic logic [9:0] model_vec();
        logic s;
        s = (m_ph == PH_START);
        return {s, s, s, s || m_first,
                (m_ph == PH_AIM) || (m_ph == PH_SHOOT), m_ph == PH_SHOOT,
                (m_ph == PH_DONE) ? 2'b00 : m_dx, m_won, m_ph == PH_END};
    endfunction

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic after_edge();
        @(posedge clk); #3;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1; launch_key = 0; key_left = 0; key_right = 0;
        collision = 0; target_out = 0; torpedo_out = 0;
        @(negedge clk);
        reset = 1'b0;
        after_edge();  // START
        after_edge();  // AIM
    endtask

    task automatic launch_with(input logic l, input logic r);
        @(negedge clk); key_left = l; key_right = r; launch_key = 1'b1;
        after_edge();
    endtask

    int run_cnt;

    initial begin
        reset = 1'b1; launch_key = 1'b1; key_left = 0; key_right = 0;
        collision = 0; target_out = 0; torpedo_out = 0;
        fork
            begin
                forever begin
                    @(posedge clk); #2;
                    if (!reset) chk("model_cmp", dut_vec, model_vec());
                end
            end
            begin
                // Reset with launch key held, then START and AIM.
                repeat (3) @(negedge clk);
                chk("reset_outputs", dut_vec, 10'b0);
                reset = 1'b0;
                after_edge();
                chk("start_pulses", dut_vec, 10'b1111_00_00_0_0);
                after_edge();
                chk("aim_idle", dut_vec, 10'b0000_10_00_0_0);
                repeat (3) after_edge();
                chk("held_key_no_launch", dut_vec, 10'b0000_10_00_0_0);

                // Right launch -> SHOOT, then win with simultaneous out event.
                @(negedge clk); launch_key = 0;
                launch_with(1'b0, 1'b1);
                chk("shoot_right", dut_vec, 10'b0001_11_01_0_0);
                after_edge();
                chk("shoot_dxy_once", dut_vec, 10'b0000_11_01_0_0);
                @(negedge clk); collision = 1; torpedo_out = 1;
                @(negedge clk); collision = 0; torpedo_out = 0;
                chk("win_end", dut_vec, 10'b0000_00_01_1_1);
                run_cnt = 0;
                for (int i = 0; i < 20; i++) begin
                    if (running) run_cnt++;
                    @(negedge clk);
                end
                checks++;
                if (run_cnt != END_CYC) begin
                    errors++;
                    $display("FAIL end_timer_len: got %0d expected %0d", run_cnt, END_CYC);
                end
                repeat (100) @(negedge clk);
`ifdef GAME_SEQUENCER_AUTO_RESTART_EN
                chk("restart_aim", dut_vec, 10'b0000_10_00_0_0);
`else
                chk("done_hold", dut_vec, 10'b0000_00_00_1_0);
`endif

                // Loss: target leaves in AIM.
                pulse_reset();
                @(negedge clk); target_out = 1;
                after_edge();
                chk("loss_aim", dut_vec, 10'b0000_00_00_0_1);
                @(negedge clk); target_out = 0;
                repeat (10) @(negedge clk);

                // Left launch, torpedo leaves -> loss, velocity held in END.
                pulse_reset();
                launch_with(1'b1, 1'b0);
                chk("shoot_left", dut_vec, 10'b0001_11_11_0_0);
                @(negedge clk); launch_key = 0; torpedo_out = 1;
                after_edge();
                chk("loss_torpedo_out", dut_vec, 10'b0000_00_11_0_1);
                @(negedge clk); torpedo_out = 0;
                repeat (10) @(negedge clk);

                // Both keys -> zero velocity, then asynchronous reset in SHOOT.
                pulse_reset();
                launch_with(1'b1, 1'b1);
                chk("shoot_both", dut_vec, 10'b0001_11_00_0_0);
                repeat (2) after_edge();
                #1 reset = 1'b1;
                #1 chk("async_reset", dut_vec, 10'b0);
                @(negedge clk); reset = 1'b0; launch_key = 0; key_left = 0; key_right = 0;
                after_edge();
                chk("start_after_reset", dut_vec, 10'b1111_00_00_0_0);
                after_edge();

                // Collision wins over target_out in AIM.
                @(negedge clk); collision = 1; target_out = 1;
                after_edge();
                chk("aim_priority", dut_vec, 10'b0000_00_00_1_1);
                @(negedge clk); collision = 0; target_out = 0;
                repeat (12) @(negedge clk);
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
